// File: rtl/pwm_pkg.sv
// Shared widths and constants for the dual-channel PWM, plus the slew helper
// used when PWM_SLEW_EN is defined.
package pwm_pkg;

  localparam int DUTY_W = 6;
  localparam int SLOTS  = 64;
  localparam int PRE_W  = 10;

  typedef logic [DUTY_W-1:0] duty_t;

  // Moves active toward target by at most step; the 7-bit intermediate keeps
  // the difference from wrapping, and clamping to the difference prevents overshoot.
  function automatic duty_t slew_toward(input duty_t active, input duty_t target,
                                        input logic [DUTY_W:0] step);
    logic [DUTY_W:0] a;
    logic [DUTY_W:0] t;
    logic [DUTY_W:0] d;
    a = {1'b0, active};
    t = {1'b0, target};
    if (t > a) begin
      d = t - a;
      if (d > step) d = step;
      slew_toward = duty_t'(a + d);
    end else begin
      d = a - t;
      if (d > step) d = step;
      slew_toward = duty_t'(a - d);
    end
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty (optionally slew limited under PWM_SLEW_EN) and registered compare.
// Duty takes effect at the boundary edge; the output reflects the same-edge slot and duty.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int SLEW_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boundary,
  input  logic [DUTY_W-1:0] dc,
  input  logic [DUTY_W-1:0] slot_next,
  output logic              pwm
);

  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_next;

`ifdef PWM_SLEW_EN
  localparam logic [DUTY_W:0] STEP = (DUTY_W+1)'(SLEW_STEP);

  always_comb begin
    duty_next = duty_q;
    if (boundary) duty_next = slew_toward(duty_q, dc, STEP);
  end
`else
  logic unused_slew;
  assign unused_slew = (SLEW_STEP != 0);

  always_comb begin
    duty_next = duty_q;
    if (boundary) duty_next = dc;
  end
`endif

  // Comparing next-state values keeps the output aligned with the slot it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      pwm    <= 1'b0;
    end else begin
      duty_q <= duty_next;
      pwm    <= (slot_next < duty_next);
    end
  end

endmodule

// File: rtl/pwm_dual.sv
// Two phase-aligned 64-slot PWM channels sharing one prescaler and slot counter.
// Duty inputs are shadowed until each period boundary; slew limiting via PWM_SLEW_EN.
module pwm_dual
  import pwm_pkg::*;
#(
  parameter int PRESCALE  = 1,
  parameter int SLEW_STEP = 4
) (
  input  logic       sysclk,
  input  logic       Reset_Sw,
  input  logic [5:0] DC_X,
  input  logic [5:0] DC_Y,
  output logic       PWM_X,
  output logic       PWM_Y,
  output logic       Period_Tick
);

  logic [PRE_W-1:0]  pre_cnt;
  logic              slot_en;
  logic [DUTY_W-1:0] slot_q;
  logic [DUTY_W-1:0] slot_next;
  logic              boundary;

  assign slot_en   = (pre_cnt == PRE_W'(PRESCALE - 1));
  assign slot_next = slot_en ? slot_q + DUTY_W'(1) : slot_q;
  assign boundary  = slot_en && (slot_q == DUTY_W'(SLOTS - 1));

  always_ff @(posedge sysclk) begin
    if (Reset_Sw) begin
      pre_cnt     <= '0;
      slot_q      <= '0;
      Period_Tick <= 1'b0;
    end else begin
      pre_cnt     <= slot_en ? '0 : pre_cnt + PRE_W'(1);
      slot_q      <= slot_next;
      Period_Tick <= boundary;
    end
  end

  pwm_channel #(.SLEW_STEP(SLEW_STEP)) u_x (
    .clk       (sysclk),
    .rst       (Reset_Sw),
    .boundary  (boundary),
    .dc        (DC_X),
    .slot_next (slot_next),
    .pwm       (PWM_X)
  );

  pwm_channel #(.SLEW_STEP(SLEW_STEP)) u_y (
    .clk       (sysclk),
    .rst       (Reset_Sw),
    .boundary  (boundary),
    .dc        (DC_Y),
    .slot_next (slot_next),
    .pwm       (PWM_Y)
  );

endmodule

// File: tb/tb_pwm_dual.sv
// Directed bench for pwm_dual: PRESCALE=1 instance for waveform/shadow/reset cases,
// PRESCALE=3 instance for period scaling; slew ramp sequence when PWM_SLEW_EN is defined.
module tb_pwm_dual;

  logic       sysclk = 1'b0;
  logic       Reset_Sw;
  logic [5:0] dc_x, dc_y, dc3_x, dc3_y;
  logic       pwm_x, pwm_y, tick;
  logic       pwm3_x, pwm3_y, tick3;

  int checks = 0;
  int errors = 0;
  int hx, hy, rx, ry, tk, n;

  always #5 sysclk = ~sysclk;

  pwm_dual #(.PRESCALE(1), .SLEW_STEP(4)) dut (
    .sysclk      (sysclk),
    .Reset_Sw    (Reset_Sw),
    .DC_X        (dc_x),
    .DC_Y        (dc_y),
    .PWM_X       (pwm_x),
    .PWM_Y       (pwm_y),
    .Period_Tick (tick)
  );

  pwm_dual #(.PRESCALE(3), .SLEW_STEP(4)) dut3 (
    .sysclk      (sysclk),
    .Reset_Sw    (Reset_Sw),
    .DC_X        (dc3_x),
    .DC_Y        (dc3_y),
    .PWM_X       (pwm3_x),
    .PWM_Y       (pwm3_y),
    .Period_Tick (tick3)
  );

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts cycles (and highs) until the selected Period_Tick is seen, bounded by budget.
  task automatic wait_tick(input bit use3, input int budget);
    logic t;
    n = 0; hx = 0; hy = 0;
    t = use3 ? tick3 : tick;
    while (t !== 1'b1 && n < budget) begin
      if ((use3 ? pwm3_x : pwm_x) === 1'b1) hx++;
      if ((use3 ? pwm3_y : pwm_y) === 1'b1) hy++;
      step();
      n++;
      t = use3 ? tick3 : tick;
    end
  endtask

  // Samples len cycles starting at a tick cycle; rx/ry are leading-high run lengths.
  task automatic measure(input bit use3, input int len, input int chg_at,
                         input logic [5:0] chg_val);
    logic px, py, pt;
    bit sx, sy;
    hx = 0; hy = 0; rx = 0; ry = 0; tk = 0; sx = 1; sy = 1;
    for (int i = 0; i < len; i++) begin
      if (i == chg_at) dc_x = chg_val;
      px = use3 ? pwm3_x : pwm_x;
      py = use3 ? pwm3_y : pwm_y;
      pt = use3 ? tick3 : tick;
      if (px === 1'b1) begin hx++; if (sx) rx++; end else sx = 0;
      if (py === 1'b1) begin hy++; if (sy) ry++; end else sy = 0;
      if (pt === 1'b1) tk++;
      step();
    end
  endtask

  initial begin
    Reset_Sw = 1'b1;
    dc_x = 6'd16; dc_y = 6'd40; dc3_x = 6'd8; dc3_y = 6'd63;
    repeat (3) step();
    check("rst_pwm_x", pwm_x, 0);
    check("rst_pwm_y", pwm_y, 0);
    check("rst_tick", tick, 0);
    check("rst_pwm3_x", pwm3_x, 0);
    check("rst_tick3", tick3, 0);

`ifndef PWM_SLEW_EN
    Reset_Sw = 1'b0;
    wait_tick(0, 100);
    check("first_period_len", n, 64);
    check("first_period_x_low", hx, 0);
    check("first_period_y_low", hy, 0);

    measure(0, 64, -1, 6'd0);
    check("p16_x_high", hx, 16);
    check("p16_x_run", rx, 16);
    check("p40_y_high", hy, 40);
    check("p40_y_run", ry, 40);
    check("p_tick_count", tk, 1);
    check("p_tick_spacing", tick, 1);

    dc_x = 6'd0; dc_y = 6'd63;
    measure(0, 64, -1, 6'd0);
    check("shadow_x_high", hx, 16);
    check("shadow_y_high", hy, 40);
    measure(0, 64, -1, 6'd0);
    check("d0_x_high", hx, 0);
    check("d63_y_high", hy, 63);
    check("d63_y_run", ry, 63);
    check("d63_tick", tk, 1);

    dc_x = 6'd16;
    measure(0, 64, -1, 6'd0);
    check("d0_x_hold", hx, 0);
    measure(0, 64, 10, 6'd32);
    check("mid_chg_x_high", hx, 16);
    check("mid_chg_x_run", rx, 16);
    measure(0, 64, -1, 6'd0);
    check("after_chg_x_high", hx, 32);
    check("after_chg_x_run", rx, 32);

    dc_x = 6'd20;
    measure(0, 64, -1, 6'd0);
    measure(0, 64, -1, 6'd0);
    check("d20_x_high", hx, 20);
    repeat (30) step();
    check("pre_rst_y_high", pwm_y, 1);
    Reset_Sw = 1'b1;
    step();
    check("mid_rst_pwm_x", pwm_x, 0);
    check("mid_rst_pwm_y", pwm_y, 0);
    check("mid_rst_tick", tick, 0);
    check("mid_rst_pwm3_y", pwm3_y, 0);
    Reset_Sw = 1'b0;
    wait_tick(0, 100);
    check("post_rst_len", n, 64);
    check("post_rst_x_low", hx, 0);
    check("post_rst_y_low", hy, 0);
    measure(0, 64, -1, 6'd0);
    check("post_rst_x_high", hx, 20);
    check("post_rst_x_run", rx, 20);

    wait_tick(1, 300);
    check("ps3_first_wait", n, 64);
    check("ps3_first_x_low", hx, 0);
    measure(1, 192, -1, 6'd0);
    check("ps3_x_high", hx, 24);
    check("ps3_x_run", rx, 24);
    check("ps3_y_high", hy, 189);
    check("ps3_tick_count", tk, 1);
    check("ps3_tick_spacing", tick3, 1);
`else
    dc_x = 6'd42;
    Reset_Sw = 1'b0;
    wait_tick(0, 100);
    check("slew_first_len", n, 64);
    for (int k = 1; k <= 12; k++) begin
      measure(0, 64, -1, 6'd0);
      check("slew_up_x_high", hx, (4 * k > 42) ? 42 : 4 * k);
    end
    dc_x = 6'd0;
    measure(0, 64, -1, 6'd0);
    check("slew_hold_x_high", hx, 42);
    for (int k = 1; k <= 11; k++) begin
      measure(0, 64, -1, 6'd0);
      check("slew_down_x_high", hx, (42 - 4 * k < 0) ? 0 : 42 - 4 * k);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_dual.md
PWM_DUAL -- requirements
Module: pwm_dual

Interface
REQ-001 Parameter PRESCALE, default 1: number of sysclk cycles per PWM slot, legal range 1..1023.
REQ-002 Parameter SLEW_STEP, default 4: maximum change of the active duty per PWM period; used only when slew limiting is compiled in.
REQ-003 sysclk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Reset_Sw  input  1  reset, synchronous and active-high.
REQ-005 DC_X  input  6  requested X duty, in slots out of 64.
REQ-006 DC_Y  input  6  requested Y duty, in slots out of 64.
REQ-007 PWM_X  output  1  registered PWM waveform for channel X.
REQ-008 PWM_Y  output  1  registered PWM waveform for channel Y.
REQ-009 Period_Tick  output  1  one-sysclk pulse at each period boundary.

Function
REQ-010 Prescaler: a counter runs 0..PRESCALE-1 and wraps; slot_en is asserted when it equals PRESCALE-1.
REQ-011 Slot counter: 6 bits, advances by 1 on slot_en, and wraps from 63 to 0; one PWM period is 64*PRESCALE sysclk cycles.
REQ-012 Boundary: the edge on which the slot counter wraps 63->0 is the period boundary; DC_X and DC_Y are sampled on that edge only.
REQ-013 Shadow rule: changes on DC_X/DC_Y mid-period have no effect until the next boundary.
REQ-014 Active duty registers (6 bits each) update only at the boundary.
REQ-015 PWM_X register is set to 1 iff (new slot count < new active X duty); PWM_Y likewise; both are updated every sysclk edge.
REQ-016 Duty 0 gives PWM constantly low; duty 63 gives high for 63 slots and low for 1 slot; the output is never 100% high.
REQ-017 Period_Tick is high for exactly the one sysclk cycle following the boundary edge, and low otherwise.
REQ-018 X and Y share one prescaler and one slot counter, so their periods are phase-aligned.
REQ-019 The comparison is unsigned; no arithmetic result wider than 6 bits is stored except as a slew intermediate (REQ-026).

Reset
REQ-020 While Reset_Sw is high at a clock edge, the following registers are set to 0: prescaler, slot counter, active duties, PWM_X, PWM_Y and Period_Tick.
REQ-021 Reset mid-period discards the period in progress.
REQ-022 After Reset_Sw deasserts, the first period starts at slot 0 with active duty 0 (output low), and the first DC sample is taken at the first boundary.
REQ-023 Reset has priority over every other update in the same cycle.

Configuration
REQ-024 Macro PWM_SLEW_EN selects slew limiting.
REQ-025 PWM_SLEW_EN undefined: at each boundary the active duty is set to the sampled DC value.
REQ-026 PWM_SLEW_EN defined: at each boundary the active duty moves toward the sampled DC by min(|target-active|, SLEW_STEP), computed in 7 bits, with no overshoot and no wrap-around.
REQ-027 PWM_SLEW_EN defined: a change in the target while a ramp is under way retargets the ramp from the current active value at the next boundary.

Structure
REQ-028 Shared package pwm_pkg holds DUTY_W=6, SLOTS=64 and the prescaler width constant; the Move block's duty outputs use the same DUTY_W.
REQ-029 Sub-module pwm_channel holds the active duty register, the optional slew logic and the output compare; it is instantiated twice (X, Y).
REQ-030 The prescaler, slot counter and Period_Tick logic reside in pwm_dual.

Verification
REQ-031 PRESCALE=1, DC_X=16, DC_Y=40, steady -> per 64-cycle period, PWM_X high 16 cycles from slot 0 and PWM_Y high 40 cycles; Period_Tick every 64 cycles.
REQ-032 DC_X=0 and DC_Y=63 -> PWM_X never high; PWM_Y high 63 cycles then low 1 cycle, every period.
REQ-033 DC_X changed 16->32 at slot 10 -> current period high 16; next period high 32; no glitch at the change.
REQ-034 PRESCALE=3, DC_X=8 -> period 192 cycles; PWM_X high 24 cycles; Period_Tick spacing 192.
REQ-035 Reset_Sw pulsed at slot 30 with DC_X=20 -> all outputs 0 the next cycle; first post-reset period fully low; second period high 20 slots.
REQ-036 PWM_SLEW_EN, SLEW_STEP=4, DC_X 0->42 -> active duty 4, 8, ... 40 over periods 1-10, then 42 in period 11; 42->0 ramps down symmetrically.
